// File: rtl/rs_pulse_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_seq_pkg
// Description : State encoding, op constants and sizing helper for the
//               RS latch pulse sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        VERIFY = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_pulse_sequencer_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Parameterized-width two-flop synchronizer, cleared by rst.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/rs_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rs_pulse_sequencer
// Description : Drives fixed-width S/R pulses into a bank of NOR RS latches,
//               one command at a time. Q readback enabled by RS_SEQ_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_pulse_sequencer
    import rs_seq_pkg::*;
#(
    parameter int N_CELLS = 8,
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 15,
    localparam int IDXW   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [IDXW-1:0]    cmd_idx,
    output logic [N_CELLS-1:0] s,
    output logic [N_CELLS-1:0] r,
    input  logic [N_CELLS-1:0] q,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int c_CNT_W = $clog2(max3(PULSE_W, GAP_W, TIMEOUT) + 1);

    localparam logic [N_CELLS-1:0] c_ONE         = N_CELLS'(1);
    localparam logic [IDXW:0]      c_N_IDX       = (IDXW + 1)'(N_CELLS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_PULSE   = c_CNT_W'(PULSE_W);
    localparam logic [c_CNT_W-1:0] c_CNT_GAP     = c_CNT_W'(GAP_W);
    localparam logic [c_CNT_W-1:0] c_CNT_TIMEOUT = c_CNT_W'(TIMEOUT);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_op;
    logic [IDXW-1:0]    r_idx;
    logic               r_bad;
    logic [N_CELLS-1:0] r_s;
    logic [N_CELLS-1:0] r_r;
    logic               r_ready;
    logic               r_done;
    logic               r_err;

    logic               w_idx_ok;
    logic [N_CELLS-1:0] w_sel;

    assign w_idx_ok = ({1'b0, cmd_idx} < c_N_IDX);
    assign w_sel    = c_ONE << cmd_idx;

`ifdef RS_SEQ_VERIFY_EN
    logic [N_CELLS-1:0] w_q_sync;
    logic               w_q_hit;

    sync2 #(.WIDTH(N_CELLS)) u_sync2 (
        .clk (clk),
        .rst (rst),
        .i_d (q),
        .o_q (w_q_sync)
    );

    assign w_q_hit = (w_q_sync[r_idx] == r_op);
`else
    logic w_unused;
    assign w_unused = ^{q, r_op, r_idx};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= OP_RST;
            r_idx   <= '0;
            r_bad   <= 1'b0;
            r_s     <= '0;
            r_r     <= '0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (cmd_valid && r_ready) begin
                        r_ready <= 1'b0;
                        r_op    <= cmd_op;
                        r_idx   <= cmd_idx;
                        r_bad   <= !w_idx_ok;
                        r_state <= PULSE;
                        if (w_idx_ok) begin
                            r_cnt <= c_CNT_PULSE;
                            r_s   <= (cmd_op == OP_SET) ? w_sel : '0;
                            r_r   <= (cmd_op == OP_RST) ? w_sel : '0;
                        end else begin
                            // Bad index: one silent PULSE cycle carries the ERR pulse
                            r_cnt <= c_CNT_ONE;
                            r_err <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (r_cnt == c_CNT_ONE) begin
                        r_s <= '0;
                        r_r <= '0;
`ifdef RS_SEQ_VERIFY_EN
                        if (r_bad) begin
                            r_state <= GAP;
                            r_cnt   <= c_CNT_GAP;
                        end else begin
                            r_state <= VERIFY;
                            r_cnt   <= c_CNT_TIMEOUT;
                        end
`else
                        r_state <= GAP;
                        r_cnt   <= c_CNT_GAP;
                        r_done  <= !r_bad;
`endif
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                VERIFY: begin
`ifdef RS_SEQ_VERIFY_EN
                    if (w_q_hit) begin
                        r_done  <= 1'b1;
                        r_state <= GAP;
                        r_cnt   <= c_CNT_GAP;
                    end else if (r_cnt == c_CNT_ONE) begin
                        r_err   <= 1'b1;
                        r_state <= GAP;
                        r_cnt   <= c_CNT_GAP;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
`else
                    r_state <= GAP;
                    r_cnt   <= c_CNT_GAP;
`endif
                end
                GAP: begin
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign s         = r_s;
    assign r         = r_r;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/rs_pulse_sequencer.md
# rs_pulse_sequencer

Sequencing controller for a bank of cross-coupled NOR RS latches. Accepts set/reset commands over a valid/ready handshake and drives the selected cell's S or R line with a fixed-width pulse. Optionally checks the latch's Q feedback, then enforces a recovery gap before the next command. Guarantees that S and R are never co-asserted, which is the forbidden input of the NOR latch, and that at most one cell is pulsed at a time.

## Interface
- N_CELLS, 8, number of latch cells driven; IDXW = clog2(N_CELLS), minimum 1
- PULSE_W, 4, S/R pulse width in cycles, ≥1
- GAP_W, 2, idle cycles with S=R=0 after each command, ≥1
- TIMEOUT, 15, maximum VERIFY cycles before error, ≥1
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  sequencer can accept a command
- CMD_OP  in  1  1 = set (pulse S), 0 = reset (pulse R)
- CMD_IDX  in  IDXW  target cell
- S  out  N_CELLS  set lines, registered
- R  out  N_CELLS  reset lines, registered
- Q  in  N_CELLS  latch Q feedback, asynchronous to CLK
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  one-cycle error pulse

## Operation
- States: IDLE, PULSE, VERIFY, GAP.
- IDLE: CMD_READY=1. Accept on CMD_VALID && CMD_READY at a rising edge. Capture op and idx, load counter=PULSE_W, go to PULSE.
- PULSE: S[idx] (op=1) or R[idx] (op=0) is high for exactly PULSE_W cycles, all other bits 0. Then go to VERIFY.
- VERIFY: compare synchronized Q[idx] against op each cycle.
  - Match: DONE pulses, go to GAP.
  - No match after TIMEOUT cycles: ERR pulses, go to GAP.
- GAP: S=R=0 for GAP_W cycles, then IDLE.
- Out-of-range idx (idx ≥ N_CELLS, only possible when N_CELLS is not a power of two): the command is accepted but no S/R pulse is driven. ERR pulses the next cycle, then GAP.
- Invariants, every cycle:
  - (S & R) == 0
  - popcount(S | R) ≤ 1
  - DONE and ERR never both high
- Q passes through a 2-flop synchronizer per bit before any comparison.
- Commands presented while not in IDLE are held off by CMD_READY=0. CMD_VALID may stay high; no command is lost or duplicated.

## Timing
- Reset values: S=0, R=0, DONE=0, ERR=0, BUSY=0, CMD_READY=0 while RST is high, state IDLE.
- CMD_READY=1 in the first cycle after RST deasserts.
- Reset mid-operation: S/R clear immediately (asynchronous). The in-flight command is dropped, with no DONE or ERR.
- Let the accept edge be cycle 0. With an ideal latch:
  - S/R high in cycles 1..PULSE_W.
  - VERIFY starts in cycle PULSE_W+1.
  - DONE is high in the cycle after the match cycle, which is the first GAP cycle.
- Default parameters, ideal latch:
  - VERIFY in cycle 5, DONE in cycle 6, GAP in cycles 6–7.
  - CMD_READY=1 in cycle 8, giving 8 cycles per command.
- Timeout, default parameters: VERIFY in cycles 5–19, ERR in cycle 20.
- Counter width is clog2(max(PULSE_W, GAP_W, TIMEOUT)+1). Counters load at state entry and count down to 1.

## Configuration
- RS_SEQ_VERIFY_EN defined:
  - VERIFY state and synchronizer present.
  - ERR reports timeout and out-of-range index.
- RS_SEQ_VERIFY_EN undefined:
  - VERIFY and synchronizer removed, Q ignored.
  - PULSE goes directly to GAP, and DONE pulses in the first GAP cycle (default: cycle 5, CMD_READY in cycle 7).
  - ERR reports only out-of-range index.

## Structure
- Package rs_seq_pkg holds the state encoding (IDLE, PULSE, VERIFY, GAP) and the op constants OP_SET=1, OP_RST=0.
- One sub-module, sync2: a parameterized-width two-flop synchronizer for Q, reset to 0 by RST.

## Test plan
- Reset: RST high with CMD_VALID=1, then release → S=R=0 throughout, CMD_READY=1 in the first cycle after release, no accept during reset.
- Set cell 3 (op=1, idx=3), with the bench latch model responding → S=8'h08 in cycles 1–4, DONE in cycle 6, CMD_READY in cycle 8.
- Back-to-back: reset cell 3, then set cell 7, with CMD_VALID held high → R=8'h08 in cycles 1–4, next accept in cycle 8, S=8'h80 in cycles 9–12, S&R=0 every cycle.
- Stuck latch: set cell 0 with Q[0] forced to 0 → ERR in cycle 20, no DONE, CMD_READY in cycle 22.
- Mid-pulse reset: assert RST in cycle 2 of a set on cell 5 → S=0 immediately, no DONE/ERR, the next command completes normally.
- N_CELLS=6: command with idx=7 → S=R=0 throughout, ERR in cycle 1, CMD_READY in cycle 4.
